// File: rtl/sq_pkg.sv
// Shared definitions for the sample queue: FSM state type and default sizing.
//   SQ_DATA_W       default channel sample width
//   SQ_DEPTH_LOW    default window length for the low band queue
//   SQ_DEPTH_HIGH   default window length for the high band queue
package sq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  localparam int unsigned SQ_DATA_W     = 16;
  localparam int unsigned SQ_DEPTH_LOW  = 1021;
  localparam int unsigned SQ_DEPTH_HIGH = 1021;

endpackage

// File: rtl/sq_dpram.sv
// Simple dual-port RAM, DEPTH x WIDTH, one write port and one registered
// read port on the same clock. No reset on storage or read data.
//   clk    clock
//   we     write enable;  waddr/wdata write address and data
//   re     read enable;   raddr read address
//   rdata  read data, updated one clock after re, held otherwise
module sq_dpram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write and synchronous read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_queue.sv
// Sample queue: captures stereo pairs on valid_in rising edges into a
// circular window of DEPTH entries; once full, each new sample triggers a
// burst readout of the whole window, oldest to newest, one pair per clock.
// A sample arriving during a burst is parked in a one-deep pending slot.
//   clk, rst_n           clock, synchronous active-low reset
//   valid_in             codec valid level (new sample on rising edge)
//   lft_in, rht_in       codec samples
//   lft_smpl, rht_smpl   burst data, held after the last beat
//   sequencing           high while burst data is valid
//   seq_done             one-cycle pulse after the last beat
//   full                 window holds DEPTH entries
//   ovf                  sticky: a sample was dropped
// Build option: define SAMPLE_QUEUE_DECIM_EN to accept only every second edge.
module sample_queue
  import sq_pkg::*;
#(
  parameter int unsigned DEPTH  = SQ_DEPTH_LOW,
  parameter int unsigned DATA_W = SQ_DATA_W,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  output logic [DATA_W-1:0] lft_smpl,
  output logic [DATA_W-1:0] rht_smpl,
  output logic              sequencing,
  output logic              seq_done,
  output logic              full,
  output logic              ovf
);

  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned PAIR_W = 2 * DATA_W;

  sq_state_t          state, state_n;
  logic [PTR_W-1:0]   new_ptr, new_ptr_n, old_ptr, old_ptr_n, rd_ptr, rd_ptr_n;
  logic [OCC_W-1:0]   occ, occ_n, rd_cnt, rd_cnt_n;
  logic               valid_q, valid_q_n, rd_q, rd_q_n;
  logic               pend_vld, pend_vld_n;
  logic [PAIR_W-1:0]  pend_data, pend_data_n;
  logic [DATA_W-1:0]  lft_n, rht_n;
  logic               sequencing_n, seq_done_n, full_n, ovf_n;
  logic               new_c, acc_c, wr_en_c, rd_en_c;
  logic [PAIR_W-1:0]  wr_data_c, rd_data;
`ifdef SAMPLE_QUEUE_DECIM_EN
  logic               tog, tog_n;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  sq_dpram #(.DEPTH(DEPTH), .WIDTH(PAIR_W), .AW(PTR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (new_ptr),
    .wdata (wr_data_c),
    .re    (rd_en_c),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      rd_cnt     <= '0;
      valid_q    <= 1'b0;
      rd_q       <= 1'b0;
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      lft_smpl   <= '0;
      rht_smpl   <= '0;
      sequencing <= 1'b0;
      seq_done   <= 1'b0;
      full       <= 1'b0;
      ovf        <= 1'b0;
`ifdef SAMPLE_QUEUE_DECIM_EN
      tog        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      new_ptr    <= new_ptr_n;
      old_ptr    <= old_ptr_n;
      rd_ptr     <= rd_ptr_n;
      occ        <= occ_n;
      rd_cnt     <= rd_cnt_n;
      valid_q    <= valid_q_n;
      rd_q       <= rd_q_n;
      pend_vld   <= pend_vld_n;
      pend_data  <= pend_data_n;
      lft_smpl   <= lft_n;
      rht_smpl   <= rht_n;
      sequencing <= sequencing_n;
      seq_done   <= seq_done_n;
      full       <= full_n;
      ovf        <= ovf_n;
`ifdef SAMPLE_QUEUE_DECIM_EN
      tog        <= tog_n;
`endif
    end
  end

  // Next-state, pointer and output logic.
  always_comb begin
    state_n      = state;
    new_ptr_n    = new_ptr;
    old_ptr_n    = old_ptr;
    rd_ptr_n     = rd_ptr;
    occ_n        = occ;
    rd_cnt_n     = rd_cnt;
    pend_vld_n   = pend_vld;
    pend_data_n  = pend_data;
    lft_n        = lft_smpl;
    rht_n        = rht_smpl;
    seq_done_n   = 1'b0;
    ovf_n        = ovf;
    wr_en_c      = 1'b0;
    wr_data_c    = {lft_in, rht_in};
    rd_en_c      = 1'b0;
    valid_q_n    = valid_in;
    new_c        = valid_in & ~valid_q;
`ifdef SAMPLE_QUEUE_DECIM_EN
    acc_c        = new_c & ~tog;
    tog_n        = tog ^ new_c;
`else
    acc_c        = new_c;
`endif

    case (state)
      IDLE: begin
        // Pending sample goes first; a coincident new edge takes its slot.
        if (pend_vld) begin
          wr_en_c   = 1'b1;
          wr_data_c = pend_data;
          if (acc_c) pend_data_n = {lft_in, rht_in};
          else       pend_vld_n  = 1'b0;
        end else if (acc_c) begin
          wr_en_c = 1'b1;
        end
        if (wr_en_c) begin
          new_ptr_n = ptr_inc(new_ptr);
          if (occ == OCC_W'(DEPTH)) old_ptr_n = ptr_inc(old_ptr);
          else                      occ_n     = occ + OCC_W'(1);
          if (occ_n == OCC_W'(DEPTH)) begin
            state_n  = READ;
            rd_ptr_n = old_ptr_n;
            rd_cnt_n = OCC_W'(DEPTH);
          end
        end
      end
      READ: begin
        // Issue DEPTH reads, then wait for the two-stage pipe to drain.
        if (rd_cnt != '0) begin
          rd_en_c  = 1'b1;
          rd_ptr_n = ptr_inc(rd_ptr);
          rd_cnt_n = rd_cnt - OCC_W'(1);
        end else if (!rd_q && sequencing) begin
          state_n    = DONE;
          seq_done_n = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Collision with an active burst: park one sample, drop the rest.
    if (state != IDLE && acc_c) begin
      if (pend_vld) begin
        ovf_n = 1'b1;
      end else begin
        pend_vld_n  = 1'b1;
        pend_data_n = {lft_in, rht_in};
      end
    end

    rd_q_n       = rd_en_c;
    sequencing_n = rd_q;
    if (rd_q) begin
      lft_n = rd_data[PAIR_W-1:DATA_W];
      rht_n = rd_data[DATA_W-1:0];
    end
    full_n = (occ_n == OCC_W'(DEPTH));
  end

endmodule
